// File: rtl/dac_source_scheduler_if.sv
// Signal bundle between the DAC source scheduler and its surroundings:
// timing enables, mode controls, the four 18-bit sources and the DAC-side status.
interface dac_source_scheduler_if;
    logic               sam_clk_ena;
    logic               sym_clk_ena;
    logic               lfsr_cycle;
    logic [1:0]         mode;
    logic [1:0]         manual_sel;
    logic               hold;
    logic signed [17:0] src0;
    logic signed [17:0] src1;
    logic signed [17:0] src2;
    logic signed [17:0] src3;
    logic [13:0]        dac_word;
    logic [1:0]         cur_sel;
    logic               blanking;
    logic               switch_pulse;
    logic [7:0]         sw_count;

    modport master (
        output sam_clk_ena, sym_clk_ena, lfsr_cycle, mode, manual_sel, hold,
        output src0, src1, src2, src3,
        input  dac_word, cur_sel, blanking, switch_pulse, sw_count
    );

    modport slave (
        input  sam_clk_ena, sym_clk_ena, lfsr_cycle, mode, manual_sel, hold,
        input  src0, src1, src2, src3,
        output dac_word, cur_sel, blanking, switch_pulse, sw_count
    );
endinterface

// File: rtl/dac_source_scheduler.sv
// Picks one of four signed 18-bit sources for the board DAC, switching manually,
// on a symbol dwell count or on LFSR cycle marks, with midscale blanking after each switch.
module dac_source_scheduler #(
    parameter int unsigned DWELL_SYMS = 1024,
    parameter int unsigned BLANK_SAMS = 8
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    dac_source_scheduler_if.slave  bus
);
    localparam logic [13:0] MIDSCALE   = 14'h2000;
    localparam logic [15:0] DWELL_LAST = 16'(DWELL_SYMS - 32'd1);
    localparam logic        HAS_BLANK  = (BLANK_SAMS > 32'd0);
    localparam logic [7:0]  BLANK_LOAD = HAS_BLANK ? 8'(BLANK_SAMS - 32'd1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_cur_sel;
    logic [13:0] r_dac_word;
    logic        r_blanking;
    logic        r_switch_pulse;
    logic [7:0]  r_sw_count;
    logic [15:0] r_dwell_cnt;
    logic [7:0]  r_blank_cnt;
    logic [1:0]  r_mode_q;

    state_t      w_state_nxt;
    logic [1:0]  w_cur_sel_nxt;
    logic [13:0] w_dac_nxt;
    logic        w_blanking_nxt;
    logic        w_pulse_nxt;
    logic [7:0]  w_sw_count_nxt;
    logic [15:0] w_dwell_nxt;
    logic [7:0]  w_blank_nxt;
    logic        w_trigger;
    logic [1:0]  w_next_sel;
    logic        w_mode_changed;
    logic [17:0] w_src;

    // Offset-binary: drop the 4 LSBs and flip the sign bit.
    function automatic logic [13:0] to_offset_binary(input logic [17:0] s);
        return {~s[17], s[16:4]};
    endfunction

    // Route the currently selected source.
    always_comb begin
        w_src = bus.src3;
        case (r_cur_sel)
            2'd0:    w_src = bus.src0;
            2'd1:    w_src = bus.src1;
            2'd2:    w_src = bus.src2;
            default: w_src = bus.src3;
        endcase
    end

    assign w_mode_changed = (bus.mode != r_mode_q);

    // Next-state and next-output logic for the scheduler FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_cur_sel_nxt  = r_cur_sel;
        w_dac_nxt      = r_dac_word;
        w_blanking_nxt = r_blanking;
        w_pulse_nxt    = 1'b0;
        w_sw_count_nxt = r_sw_count;
        w_dwell_nxt    = r_dwell_cnt;
        w_blank_nxt    = r_blank_cnt;
        w_trigger      = 1'b0;
        w_next_sel     = r_cur_sel;

        case (r_state)
            ST_IDLE: begin
                w_dac_nxt   = MIDSCALE;
                w_dwell_nxt = 16'd0;
                if (bus.sym_clk_ena) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (bus.sam_clk_ena) begin
                    w_dac_nxt = to_offset_binary(w_src);
                end else begin
                    w_dac_nxt = r_dac_word;
                end
                if (bus.sym_clk_ena) begin
                    case (bus.mode)
                        2'b01: begin
                            if (bus.hold) begin
                                w_dwell_nxt = r_dwell_cnt;
                            end else if (r_dwell_cnt == DWELL_LAST) begin
                                w_trigger   = 1'b1;
                                w_next_sel  = r_cur_sel + 2'd1;
                                w_dwell_nxt = 16'd0;
                            end else begin
                                w_dwell_nxt = r_dwell_cnt + 16'd1;
                            end
                        end
                        2'b10: begin
                            if (bus.lfsr_cycle && !bus.hold) begin
                                w_trigger  = 1'b1;
                                w_next_sel = r_cur_sel + 2'd1;
                            end else begin
                                w_trigger  = 1'b0;
                            end
                        end
                        default: begin
                            if (bus.manual_sel != r_cur_sel) begin
                                w_trigger  = 1'b1;
                                w_next_sel = bus.manual_sel;
                            end else begin
                                w_trigger  = 1'b0;
                            end
                        end
                    endcase
                end else begin
                    w_trigger = 1'b0;
                end
                // A mode change always restarts the dwell, whatever else happened.
                if (w_mode_changed) begin
                    w_dwell_nxt = 16'd0;
                end else begin
                    w_dwell_nxt = w_dwell_nxt;
                end
                if (w_trigger) begin
                    w_cur_sel_nxt  = w_next_sel;
                    w_pulse_nxt    = 1'b1;
                    w_sw_count_nxt = r_sw_count + 8'd1;
                    w_dac_nxt      = MIDSCALE;
                    if (HAS_BLANK) begin
                        w_blank_nxt    = BLANK_LOAD;
                        w_state_nxt    = ST_BLANK;
                        w_blanking_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_BLANK: begin
                w_dac_nxt   = MIDSCALE;
                w_dwell_nxt = 16'd0;
                if (bus.sam_clk_ena) begin
                    // The exit enable already carries the new source sample.
                    if (r_blank_cnt == 8'd0) begin
                        w_state_nxt    = ST_RUN;
                        w_blanking_nxt = 1'b0;
                        w_dac_nxt      = to_offset_binary(w_src);
                    end else begin
                        w_blank_nxt = r_blank_cnt - 8'd1;
                    end
                end else begin
                    w_blank_nxt = r_blank_cnt;
                end
            end

            default: begin
                w_state_nxt    = ST_IDLE;
                w_dac_nxt      = MIDSCALE;
                w_blanking_nxt = 1'b0;
                w_dwell_nxt    = 16'd0;
                w_blank_nxt    = 8'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output and counter registers.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_cur_sel      <= 2'd0;
            r_dac_word     <= MIDSCALE;
            r_blanking     <= 1'b0;
            r_switch_pulse <= 1'b0;
            r_sw_count     <= 8'd0;
            r_dwell_cnt    <= 16'd0;
            r_blank_cnt    <= 8'd0;
            r_mode_q       <= 2'd0;
        end else begin
            r_cur_sel      <= w_cur_sel_nxt;
            r_dac_word     <= w_dac_nxt;
            r_blanking     <= w_blanking_nxt;
            r_switch_pulse <= w_pulse_nxt;
            r_sw_count     <= w_sw_count_nxt;
            r_dwell_cnt    <= w_dwell_nxt;
            r_blank_cnt    <= w_blank_nxt;
            r_mode_q       <= bus.mode;
        end
    end

    assign bus.dac_word     = r_dac_word;
    assign bus.cur_sel      = r_cur_sel;
    assign bus.blanking     = r_blanking;
    assign bus.switch_pulse = r_switch_pulse;
    assign bus.sw_count     = r_sw_count;
endmodule

// File: tb/tb_dac_source_scheduler.sv
// Directed bench for dac_source_scheduler: a vector table for the manual path,
// plus hand-written sequences for dwell, LFSR, reset-in-blank and mode changes.
module tb_dac_source_scheduler;
    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic        t_sam = 1'b0, t_sym = 1'b0, t_lfsr = 1'b0, t_hold = 1'b0;
    logic [1:0]  t_mode = 2'd0, t_msel = 2'd0;
    logic [17:0] t_src0 = 18'h1FFFF, t_src1 = 18'h12345, t_src2 = 18'h0ABCD, t_src3 = 18'h3C000;

    dac_source_scheduler_if bus_a();
    dac_source_scheduler_if bus_b();

    assign bus_a.sam_clk_ena = t_sam;   assign bus_b.sam_clk_ena = t_sam;
    assign bus_a.sym_clk_ena = t_sym;   assign bus_b.sym_clk_ena = t_sym;
    assign bus_a.lfsr_cycle  = t_lfsr;  assign bus_b.lfsr_cycle  = t_lfsr;
    assign bus_a.mode        = t_mode;  assign bus_b.mode        = t_mode;
    assign bus_a.manual_sel  = t_msel;  assign bus_b.manual_sel  = t_msel;
    assign bus_a.hold        = t_hold;  assign bus_b.hold        = t_hold;
    assign bus_a.src0        = t_src0;  assign bus_b.src0        = t_src0;
    assign bus_a.src1        = t_src1;  assign bus_b.src1        = t_src1;
    assign bus_a.src2        = t_src2;  assign bus_b.src2        = t_src2;
    assign bus_a.src3        = t_src3;  assign bus_b.src3        = t_src3;

    dac_source_scheduler #(.DWELL_SYMS(4), .BLANK_SAMS(8)) u_dut_blank (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus_a.slave)
    );

    dac_source_scheduler #(.DWELL_SYMS(4), .BLANK_SAMS(0)) u_dut_noblank (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus_b.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        sam;
        logic        sym;
        logic [1:0]  msel;
        logic [17:0] s0;
        logic [13:0] dac;
        logic [1:0]  sel;
        logic        blank;
        logic        pulse;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [0:21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_a(input string name, input logic [13:0] dac, input logic [1:0] sel,
                         input logic blank, input logic pulse, input logic [7:0] cnt);
        chk({name, ".dac_word"},     32'(bus_a.dac_word),     32'(dac));
        chk({name, ".cur_sel"},      32'(bus_a.cur_sel),      32'(sel));
        chk({name, ".blanking"},     32'(bus_a.blanking),     32'(blank));
        chk({name, ".switch_pulse"}, 32'(bus_a.switch_pulse), 32'(pulse));
        chk({name, ".sw_count"},     32'(bus_a.sw_count),     32'(cnt));
    endtask

    // One sys_clk with the given enables; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic sam, input logic sym, input logic lfsr);
        t_sam = sam; t_sym = sym; t_lfsr = lfsr;
        @(posedge sys_clk);
        #1;
        t_sam = 1'b0; t_sym = 1'b0; t_lfsr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        //            sam   sym   msel  src0       dac     sel   blank pulse cnt
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 18'h1FFFF, 14'h2000, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 2'd0, 18'h1FFFF, 14'h2000, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 2'd0, 18'h1FFFF, 14'h2000, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 18'h1FFFF, 14'h2000, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 2'd0, 18'h1FFFF, 14'h3FFF, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 18'h20000, 14'h3FFF, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 2'd0, 18'h20000, 14'h0000, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{1'b1, 1'b0, 2'd0, 18'h3FFF0, 14'h1FFF, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{1'b1, 1'b1, 2'd0, 18'h00010, 14'h2001, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[9]  = '{1'b1, 1'b0, 2'd0, 18'h0000F, 14'h2000, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b1, 1'b0, 2'd2, 18'h1FFFF, 14'h3FFF, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[11] = '{1'b1, 1'b1, 2'd2, 18'h1FFFF, 14'h2000, 2'd2, 1'b1, 1'b1, 8'd1};
        tbl[12] = '{1'b0, 1'b0, 2'd2, 18'h1FFFF, 14'h2000, 2'd2, 1'b1, 1'b0, 8'd1};
        tbl[13] = '{1'b1, 1'b0, 2'd2, 18'h1FFFF, 14'h2000, 2'd2, 1'b1, 1'b0, 8'd1};
        tbl[14] = '{1'b1, 1'b0, 2'd2, 18'h1FFFF, 14'h2000, 2'd2, 1'b1, 1'b0, 8'd1};
        tbl[15] = '{1'b1, 1'b0, 2'd2, 18'h1FFFF, 14'h2000, 2'd2, 1'b1, 1'b0, 8'd1};
        tbl[16] = '{1'b1, 1'b1, 2'd2, 18'h1FFFF, 14'h2000, 2'd2, 1'b1, 1'b0, 8'd1};
        tbl[17] = '{1'b1, 1'b0, 2'd2, 18'h1FFFF, 14'h2000, 2'd2, 1'b1, 1'b0, 8'd1};
        tbl[18] = '{1'b1, 1'b0, 2'd2, 18'h1FFFF, 14'h2000, 2'd2, 1'b1, 1'b0, 8'd1};
        tbl[19] = '{1'b1, 1'b0, 2'd2, 18'h1FFFF, 14'h2000, 2'd2, 1'b1, 1'b0, 8'd1};
        tbl[20] = '{1'b1, 1'b0, 2'd2, 18'h1FFFF, 14'h2ABC, 2'd2, 1'b0, 1'b0, 8'd1};
        tbl[21] = '{1'b1, 1'b1, 2'd2, 18'h1FFFF, 14'h2ABC, 2'd2, 1'b0, 1'b0, 8'd1};

        // Reset values, sampled while reset is still held.
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk_a("reset", 14'h2000, 2'd0, 1'b0, 1'b0, 8'd0);
        reset = 1'b0;

        // Manual mode: IDLE hold, conversion, mid-symbol request, 8-sample blank.
        for (int i = 0; i <= 21; i++) begin
            t_msel = tbl[i].msel;
            t_src0 = tbl[i].s0;
            cyc(tbl[i].sam, tbl[i].sym, 1'b0);
            chk_a($sformatf("tbl[%0d]", i), tbl[i].dac, tbl[i].sel, tbl[i].blank,
                  tbl[i].pulse, tbl[i].cnt);
        end

        // Dwell of 4 without blanking: advance every 4th symbol, count wraps at 256.
        t_mode = 2'b01; t_msel = 2'd0; t_src0 = 18'h1FFFF;
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 1024; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk("dwell.cur_sel",      32'(bus_b.cur_sel),      32'((k / 4) % 4));
            chk("dwell.sw_count",     32'(bus_b.sw_count),     32'((k / 4) % 256));
            chk("dwell.switch_pulse", 32'(bus_b.switch_pulse), 32'((k % 4) == 0));
            if (k == 4) begin
                chk("dwell.dac_on_switch", 32'(bus_b.dac_word), 32'h2000);
                chk("dwell.blanking",      32'(bus_b.blanking), 32'h0);
            end
            if (k == 5) chk("dwell.dac_src1", 32'(bus_b.dac_word), 32'h3234);
            if (k == 1020) chk("dwell.count_255", 32'(bus_b.sw_count), 32'd255);
        end

        // LFSR mode: advance, ignored during blank, hold blocks, then advance again.
        t_mode = 2'b10;
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk_a("lfsr.first", 14'h2000, 2'd1, 1'b1, 1'b1, 8'd1);
        cyc(1'b1, 1'b1, 1'b1);
        chk_a("lfsr.in_blank", 14'h2000, 2'd1, 1'b1, 1'b0, 8'd1);
        repeat (7) cyc(1'b1, 1'b0, 1'b0);
        chk("lfsr.blank_done", 32'(bus_a.blanking), 32'h0);
        t_hold = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        chk_a("lfsr.hold", 14'h3234, 2'd1, 1'b0, 1'b0, 8'd1);
        t_hold = 1'b0;
        cyc(1'b1, 1'b1, 1'b0);
        chk("lfsr.no_mark", 32'(bus_a.cur_sel), 32'd1);
        cyc(1'b1, 1'b1, 1'b1);
        chk_a("lfsr.second", 14'h2000, 2'd2, 1'b1, 1'b1, 8'd2);

        // Reset in the middle of a dwell-triggered blank, then a full dwell again.
        t_mode = 2'b01;
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        chk("rstblk.pre_sel", 32'(bus_a.cur_sel), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk_a("rstblk.switch", 14'h2000, 2'd1, 1'b1, 1'b1, 8'd1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        chk_a("rstblk.reset", 14'h2000, 2'd0, 1'b0, 1'b0, 8'd0);
        reset = 1'b0;
        cyc(1'b1, 1'b1, 1'b0);
        chk("rstblk.idle_to_run", 32'(bus_a.dac_word), 32'h2000);
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        chk("rstblk.dwell3", 32'(bus_a.cur_sel), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("rstblk.dwell4_sel", 32'(bus_a.cur_sel), 32'd1);
        chk("rstblk.dwell4_cnt", 32'(bus_a.sw_count), 32'd1);

        // Mode 01 part-way, manual with matching select, back to 01: full dwell needed.
        t_mode = 2'b01; t_msel = 2'd0;
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        t_mode = 2'b00;
        cyc(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk("modechg.manual_pulse", 32'(bus_a.switch_pulse), 32'h0);
            chk("modechg.manual_sel",   32'(bus_a.cur_sel),      32'd0);
        end
        t_mode = 2'b01;
        cyc(1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        chk("modechg.dwell3_sel", 32'(bus_a.cur_sel),  32'd0);
        chk("modechg.dwell3_cnt", 32'(bus_a.sw_count), 32'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk_a("modechg.dwell4", 14'h2000, 2'd1, 1'b1, 1'b1, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
